irq_service_ctrl: RTL and testbench

- Interrupt service controller in front of the 4-way priority-select datapath.
- Captures per-source interrupt requests and their 8-bit payloads, applies a software mask, and arbitrates with fixed priority (bit 3 highest).
- Presents exactly one interrupt at a time to a consumer over a valid/ready handshake.
- Tracks per-source overruns.

---
 rtl/irq_service_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_irq_service_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_service_ctrl.sv
// irq_service_ctrl: captures per-source interrupt requests and payloads,
// applies a software mask, and presents one interrupt at a time, chosen by
// fixed priority (highest index wins), over a valid/ready handshake.
// Every output comes straight from a register, so there is no combinational
// path from irq_i or irq_ready_i to any output.
module irq_service_ctrl #(
    parameter int N_SRC = 4,
    parameter int DW    = 8,
    parameter int IDW   = $clog2(N_SRC)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SRC-1:0]    irq_i,
    input  logic [N_SRC*DW-1:0] data_i,
    input  logic                mask_we_i,
    input  logic [N_SRC-1:0]    mask_wdata_i,
    output logic                irq_valid_o,
    input  logic                irq_ready_i,
    output logic [IDW-1:0]      irq_id_o,
    output logic [DW-1:0]       irq_data_o,
    output logic [N_SRC-1:0]    grant_o,
    output logic [N_SRC-1:0]    pending_o,
    output logic [N_SRC-1:0]    mask_o,
    output logic [N_SRC-1:0]    overrun_o,
    input  logic [N_SRC-1:0]    overrun_clr_i
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   r_overrun;
    logic [N_SRC-1:0]   r_mask;
    logic [DW-1:0]      r_buf [N_SRC];

    logic               r_valid;
    logic [IDW-1:0]     r_id;
    logic [DW-1:0]      r_data;
    logic [N_SRC-1:0]   r_grant;

    logic               w_validNext;
    logic [IDW-1:0]     w_idNext;
    logic [DW-1:0]      w_dataNext;
    logic [N_SRC-1:0]   w_grantNext;

    logic               w_handshake;
    logic [N_SRC-1:0]   w_clrPend;
    logic [N_SRC-1:0]   w_capture;
    logic [N_SRC-1:0]   w_ovrSet;
    logic [N_SRC-1:0]   w_pendingNext;
    logic [N_SRC-1:0]   w_req;
    logic               w_reqAny;
    logic [IDW-1:0]     w_selId;

    // The handshake can only happen while an interrupt is presented.
    assign w_handshake = r_valid & irq_ready_i;

    // Per-source capture decision; a new request arriving in the same cycle
    // as the handshake for that source re-arms it instead of overrunning.
    always_comb begin
        w_clrPend = '0;
        w_capture = '0;
        w_ovrSet  = '0;
        for (int n = 0; n < N_SRC; n++) begin
            w_clrPend[n] = w_handshake && (r_id == IDW'(n));
            w_capture[n] = irq_i[n] && (!r_pending[n] || w_clrPend[n]);
            w_ovrSet[n]  = irq_i[n] && r_pending[n] && !w_clrPend[n];
        end
        w_pendingNext = (r_pending & ~w_clrPend) | w_capture;
    end

    // Pending, payload buffers, sticky overrun flags (set beats clear) and mask.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
            r_overrun <= '0;
            r_mask    <= '1;
            for (int n = 0; n < N_SRC; n++) begin
                r_buf[n] <= '0;
            end
        end else begin
            r_pending <= w_pendingNext;
            r_overrun <= (r_overrun & ~overrun_clr_i) | w_ovrSet;
            if (mask_we_i) begin
                r_mask <= mask_wdata_i;
            end
            for (int n = 0; n < N_SRC; n++) begin
                if (w_capture[n]) begin
                    r_buf[n] <= data_i[n*DW +: DW];
                end
            end
        end
    end

    // Fixed-priority pick among enabled pending sources; highest index wins.
    always_comb begin
        w_req    = r_pending & r_mask;
        w_reqAny = |w_req;
        w_selId  = '0;
        for (int n = 0; n < N_SRC; n++) begin
            if (w_req[n]) begin
                w_selId = IDW'(n);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state and next presented interrupt; held unchanged while presenting.
    always_comb begin
        w_stateNext = r_state;
        w_validNext = r_valid;
        w_idNext    = r_id;
        w_dataNext  = r_data;
        w_grantNext = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_reqAny) begin
                    w_stateNext = ST_PRESENT;
                    w_validNext = 1'b1;
                    w_idNext    = w_selId;
                    w_dataNext  = r_buf[w_selId];
                    w_grantNext = {{(N_SRC-1){1'b0}}, 1'b1} << w_selId;
                end else begin
                    w_validNext = 1'b0;
                    w_idNext    = '0;
                    w_dataNext  = '0;
                    w_grantNext = '0;
                end
            end
            ST_PRESENT: begin
                if (w_handshake) begin
                    w_stateNext = ST_IDLE;
                    w_validNext = 1'b0;
                    w_idNext    = '0;
                    w_dataNext  = '0;
                    w_grantNext = '0;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_validNext = 1'b0;
                w_idNext    = '0;
                w_dataNext  = '0;
                w_grantNext = '0;
            end
        endcase
    end

    // Registered presentation outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_data  <= '0;
            r_grant <= '0;
        end else begin
            r_valid <= w_validNext;
            r_id    <= w_idNext;
            r_data  <= w_dataNext;
            r_grant <= w_grantNext;
        end
    end

    assign irq_valid_o = r_valid;
    assign irq_id_o    = r_id;
    assign irq_data_o  = r_data;
    assign grant_o     = r_grant;
    assign pending_o   = r_pending;
    assign mask_o      = r_mask;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_irq_service_ctrl.sv
// Testbench for irq_service_ctrl: directed scenarios plus random traffic,
// checked against a behavioural model of the interrupt controller.
module tb_irq_service_ctrl;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int IDW = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    irq_i;
    logic [N*DW-1:0] data_i;
    logic            mask_we_i;
    logic [N-1:0]    mask_wdata_i;
    logic            irq_valid_o;
    logic            irq_ready_i;
    logic [IDW-1:0]  irq_id_o;
    logic [DW-1:0]   irq_data_o;
    logic [N-1:0]    grant_o;
    logic [N-1:0]    pending_o;
    logic [N-1:0]    mask_o;
    logic [N-1:0]    overrun_o;
    logic [N-1:0]    overrun_clr_i;

    irq_service_ctrl #(.N_SRC(N), .DW(DW)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .irq_i         (irq_i),
        .data_i        (data_i),
        .mask_we_i     (mask_we_i),
        .mask_wdata_i  (mask_wdata_i),
        .irq_valid_o   (irq_valid_o),
        .irq_ready_i   (irq_ready_i),
        .irq_id_o      (irq_id_o),
        .irq_data_o    (irq_data_o),
        .grant_o       (grant_o),
        .pending_o     (pending_o),
        .mask_o        (mask_o),
        .overrun_o     (overrun_o),
        .overrun_clr_i (overrun_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [7:0]  data;
    } exp_t;

    exp_t expQ[$];

    // Behavioural model: what the controller owes the consumer
    bit [N-1:0]  mPend;
    bit [N-1:0]  mOvr;
    bit [N-1:0]  mMask;
    logic [7:0]  mBuf [N];
    bit          mPres;
    int          mId;
    logic [7:0]  mData;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input logic [7:0] d3, input logic [7:0] d2,
                                          input logic [7:0] d1, input logic [7:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic modelReset();
        mPend = '0;
        mOvr  = '0;
        mMask = '1;
        for (int n = 0; n < N; n++) mBuf[n] = 8'h00;
        mPres = 1'b0;
        mId   = 0;
        mData = 8'h00;
        expQ.delete();
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        bit          hs;
        bit [N-1:0]  oldPend;
        bit [N-1:0]  oldMask;
        logic [7:0]  oldBuf [N];
        bit          found;
        exp_t        e;
        hs      = mPres && irq_ready_i;
        oldPend = mPend;
        oldMask = mMask;
        oldBuf  = mBuf;
        for (int n = 0; n < N; n++) begin
            bit served;
            bit setOvr;
            served = hs && (mId == n);
            setOvr = 1'b0;
            if (irq_i[n]) begin
                if (!oldPend[n] || served) begin
                    mPend[n] = 1'b1;
                    mBuf[n]  = data_i[n*DW +: DW];
                end else begin
                    setOvr = 1'b1;
                end
            end else if (served) begin
                mPend[n] = 1'b0;
            end
            if (setOvr) mOvr[n] = 1'b1;
            else if (overrun_clr_i[n]) mOvr[n] = 1'b0;
        end
        if (mPres) begin
            if (hs) mPres = 1'b0;
        end else begin
            found = 1'b0;
            for (int n = N-1; n >= 0; n--) begin
                if (!found && oldPend[n] && oldMask[n]) begin
                    found  = 1'b1;
                    mPres  = 1'b1;
                    mId    = n;
                    mData  = oldBuf[n];
                    e.id   = n;
                    e.data = oldBuf[n];
                    expQ.push_back(e);
                end
            end
        end
        if (mask_we_i) mMask = mask_wdata_i;
    endtask

    task automatic checkCycle();
        logic [N-1:0] g;
        g = 4'b0001 << mId;
        checkOutput("valid",   32'(irq_valid_o), 32'(mPres));
        checkOutput("id",      32'(irq_id_o),    mPres ? 32'(mId) : 32'd0);
        checkOutput("data",    32'(irq_data_o),  mPres ? 32'(mData) : 32'd0);
        checkOutput("grant",   32'(grant_o),     mPres ? 32'(g) : 32'd0);
        checkOutput("pending", 32'(pending_o),   32'(mPend));
        checkOutput("overrun", 32'(overrun_o),   32'(mOvr));
        checkOutput("mask",    32'(mask_o),      32'(mMask));
    endtask

    // One clock cycle: drive inputs, step the model, clock, compare.
    task automatic applyStimulus(input logic [N-1:0] irq, input logic [31:0] data,
                                 input logic rdy, input logic mwe,
                                 input logic [N-1:0] mwd, input logic [N-1:0] clr);
        irq_i         = irq;
        data_i        = data;
        irq_ready_i   = rdy;
        mask_we_i     = mwe;
        mask_wdata_i  = mwd;
        overrun_clr_i = clr;
        modelStep();
        @(posedge clk_i);
        #1;
        checkCycle();
    endtask

    task automatic idleCycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus('0, '0, rdy, 1'b0, '0, '0);
    endtask

    task automatic resetDut();
        irq_i = '0; data_i = '0; irq_ready_i = 1'b0;
        mask_we_i = 1'b0; mask_wdata_i = '0; overrun_clr_i = '0;
        rst_ni = 1'b0;
        modelReset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Monitor: every accepted interrupt must match the next expected one.
    exp_t monE;
    always @(negedge clk_i) begin
        if (rst_ni && irq_valid_o && irq_ready_i) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_handshake", 32'd1, 32'd0);
            end else begin
                monE = expQ.pop_front();
                checkOutput("hs_id",    32'(irq_id_o),   32'(monE.id));
                checkOutput("hs_data",  32'(irq_data_o), 32'(monE.data));
                checkOutput("hs_grant", 32'(grant_o),    32'(4'b0001 << monE.id));
            end
        end
    end

    initial begin
        irq_i = '0; data_i = '0; irq_ready_i = 1'b0;
        mask_we_i = 1'b0; mask_wdata_i = '0; overrun_clr_i = '0;
        rst_ni = 1'b0;
        modelReset();
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_valid",   32'(irq_valid_o), 32'd0);
        checkOutput("rst_pending", 32'(pending_o),   32'd0);
        checkOutput("rst_overrun", 32'(overrun_o),   32'd0);
        checkOutput("rst_mask",    32'(mask_o),      32'hF);
        checkOutput("rst_grant",   32'(grant_o),     32'd0);
        rst_ni = 1'b1;

        $display("[TB] single request");
        applyStimulus(4'b0010, pack4(8'h00, 8'h00, 8'h5A, 8'h00), 1'b1, 1'b0, '0, '0);
        checkOutput("single_pend", 32'(pending_o), 32'h2);
        idleCycles(1, 1'b1);
        checkOutput("single_valid", 32'(irq_valid_o), 32'd1);
        checkOutput("single_id",    32'(irq_id_o),    32'd1);
        checkOutput("single_data",  32'(irq_data_o),  32'h5A);
        idleCycles(1, 1'b1);
        checkOutput("single_pend_clr", 32'(pending_o), 32'h0);
        idleCycles(2, 1'b1);

        $display("[TB] priority");
        applyStimulus(4'b1011, pack4(8'hA3, 8'h00, 8'hB1, 8'hC0), 1'b1, 1'b0, '0, '0);
        idleCycles(8, 1'b1);

        $display("[TB] no preemption");
        applyStimulus(4'b0001, pack4(8'h00, 8'h00, 8'h00, 8'hC5), 1'b0, 1'b0, '0, '0);
        idleCycles(2, 1'b0);
        applyStimulus(4'b1000, pack4(8'h7E, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0, '0, '0);
        idleCycles(3, 1'b0);
        checkOutput("nopre_id",   32'(irq_id_o),   32'd0);
        checkOutput("nopre_data", 32'(irq_data_o), 32'hC5);
        idleCycles(6, 1'b1);

        $display("[TB] overrun");
        applyStimulus(4'b0100, pack4(8'h00, 8'h11, 8'h00, 8'h00), 1'b0, 1'b0, '0, '0);
        applyStimulus(4'b0100, pack4(8'h00, 8'h22, 8'h00, 8'h00), 1'b0, 1'b0, '0, '0);
        checkOutput("ovr_flag", 32'(overrun_o),  32'h4);
        checkOutput("ovr_data", 32'(irq_data_o), 32'h11);
        applyStimulus(4'b0100, pack4(8'h00, 8'h33, 8'h00, 8'h00), 1'b0, 1'b0, '0, 4'b0100);
        checkOutput("ovr_set_wins", 32'(overrun_o), 32'h4);
        applyStimulus('0, '0, 1'b1, 1'b0, '0, 4'b0100);
        checkOutput("ovr_cleared", 32'(overrun_o), 32'h0);
        idleCycles(3, 1'b1);

        $display("[TB] mask");
        resetDut();
        applyStimulus('0, '0, 1'b1, 1'b1, 4'b0111, '0);
        applyStimulus(4'b1000, pack4(8'h9C, 8'h00, 8'h00, 8'h00), 1'b1, 1'b0, '0, '0);
        idleCycles(2, 1'b1);
        checkOutput("mask_pend",  32'(pending_o),   32'h8);
        checkOutput("mask_valid", 32'(irq_valid_o), 32'd0);
        applyStimulus('0, '0, 1'b0, 1'b1, 4'b1111, '0);
        idleCycles(1, 1'b0);
        checkOutput("unmask_valid", 32'(irq_valid_o), 32'd1);
        checkOutput("unmask_id",    32'(irq_id_o),    32'd3);
        checkOutput("unmask_data",  32'(irq_data_o),  32'h9C);
        idleCycles(3, 1'b1);

        $display("[TB] async reset mid-presentation");
        applyStimulus(4'b0010, pack4(8'h00, 8'h00, 8'h44, 8'h00), 1'b0, 1'b1, 4'b0011, '0);
        applyStimulus(4'b0010, pack4(8'h00, 8'h00, 8'h55, 8'h00), 1'b0, 1'b0, '0, '0);
        checkOutput("pre_rst_valid", 32'(irq_valid_o), 32'd1);
        irq_i = '0; data_i = '0; irq_ready_i = 1'b0;
        mask_we_i = 1'b0; mask_wdata_i = '0; overrun_clr_i = '0;
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("arst_valid",   32'(irq_valid_o), 32'd0);
        checkOutput("arst_pending", 32'(pending_o),   32'd0);
        checkOutput("arst_overrun", 32'(overrun_o),   32'd0);
        checkOutput("arst_mask",    32'(mask_o),      32'hF);
        modelReset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            applyStimulus(N'($urandom & $urandom & $urandom), $urandom,
                          1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 15) == 0), N'($urandom),
                          N'($urandom & $urandom));
        end
        applyStimulus('0, '0, 1'b1, 1'b1, 4'b1111, '0);
        idleCycles(20, 1'b1);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
